// File: rtl/cla_group_adder.sv
// cla_group_adder: multi-cycle adder that computes one GROUP-bit carry-lookahead
// group per clock, least-significant group first.
// Build option: define CLA_SUB_EN to add the sub port and a - b support.
//
// Ports:
//   clk, rst     - clock and synchronous active-high reset
//   start        - new request; sampled only in IDLE or DONE
//   a, b, cin    - operands and carry-in, captured when start is accepted
//   sub          - (CLA_SUB_EN only) captured; selects a + ~b + 1
//   busy         - high while groups are being computed
//   done         - one-cycle pulse; s/cout/ovf are valid from then on
//   s, cout, ovf - sum, carry out of MSB, two's-complement overflow
//
// Latency: done asserts NG cycles after the edge that accepted start.
// A start seen in the DONE cycle is accepted with no idle bubble.

module cla_group_adder #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef CLA_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int NG = WIDTH / GROUP;
  localparam int IW = $clog2(NG + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] a_r, b_r, s_r;
  logic             carry, cout_r, ovf_r;
  logic             accept, last;

  logic [GROUP-1:0] ga, gb, gp, gg, gsum;
  logic [GROUP:0]   gc;
  logic             prod, acc;

  assign accept = start && ((state == IDLE) || (state == DONE));
  assign last   = (idx == IW'(NG - 1));

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- current group select ----------------
  always_comb begin
    ga = '0;
    gb = '0;
    for (int g = 0; g < NG; g++) begin
      if (idx == IW'(g)) begin
        ga = a_r[g*GROUP +: GROUP];
        gb = b_r[g*GROUP +: GROUP];
      end
    end
  end

  assign gp = ga ^ gb;
  assign gg = ga & gb;

  // Lookahead carries: each c[i+1] is a flat sum of products over the
  // group's g/p bits and the incoming carry, with no dependence on c[i].
  always_comb begin
    gc    = '0;
    gc[0] = carry;
    prod  = 1'b0;
    acc   = 1'b0;
    for (int i = 0; i < GROUP; i++) begin
      acc = 1'b0;
      for (int j = 0; j <= i; j++) begin
        prod = gg[j];
        for (int k = j + 1; k <= i; k++) prod = prod & gp[k];
        acc = acc | prod;
      end
      prod = carry;
      for (int k = 0; k <= i; k++) prod = prod & gp[k];
      gc[i+1] = acc | prod;
    end
  end

  assign gsum = gp ^ gc[GROUP-1:0];

  // ---------------- datapath ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      idx    <= '0;
      a_r    <= '0;
      b_r    <= '0;
      s_r    <= '0;
      carry  <= 1'b0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else if (accept) begin
      idx    <= '0;
      a_r    <= a;
      s_r    <= '0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
`ifdef CLA_SUB_EN
      // Subtraction is a + ~b + 1; the caller's cin plays no part.
      b_r    <= sub ? ~b : b;
      carry  <= sub ? 1'b1 : cin;
`else
      b_r    <= b;
      carry  <= cin;
`endif
    end else if (state == RUN) begin
      for (int g = 0; g < NG; g++) begin
        if (idx == IW'(g)) s_r[g*GROUP +: GROUP] <= gsum;
      end
      carry <= gc[GROUP];
      idx   <= idx + IW'(1);
      if (last) begin
        // In the top group gc[GROUP-1] is the carry into bit WIDTH-1.
        cout_r <= gc[GROUP];
        ovf_r  <= gc[GROUP-1] ^ gc[GROUP];
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign s    = s_r;
  assign cout = cout_r;
  assign ovf  = ovf_r;

endmodule

// File: tb/tb_cla_group_adder.sv
module tb_cla_group_adder;

  localparam int WIDTH = 16;
  localparam int GROUP = 4;
  localparam int NG    = WIDTH / GROUP;
  localparam int PER   = 10;
`ifdef CLA_SUB_EN
  localparam bit SUB_ON = 1'b1;
`else
  localparam bit SUB_ON = 1'b0;
`endif

  logic             clk, rst, start, cin, sub;
  logic [WIDTH-1:0] a, b, s;
  logic             busy, done, cout, ovf;

  cla_group_adder #(.WIDTH(WIDTH), .GROUP(GROUP)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef CLA_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .s     (s),
    .cout  (cout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #(PER/2) clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] s;
    logic             c;
    logic             v;
    longint           t;   // time of the edge after which done must show
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;

  // Reference: plain integer addition at full precision.
  function automatic exp_t model(input logic [WIDTH-1:0] ma, mb,
                                 input logic mc, ms, input longint tacc);
    exp_t             r;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] bb;
    logic             ci, use_sub;
    use_sub = SUB_ON && ms;
    bb  = use_sub ? ~mb : mb;
    ci  = use_sub ? 1'b1 : mc;
    sum = {1'b0, ma} + {1'b0, bb} + {{WIDTH{1'b0}}, ci};
    r.s = sum[WIDTH-1:0];
    r.c = sum[WIDTH];
    r.v = (ma[WIDTH-1] == bb[WIDTH-1]) && (sum[WIDTH-1] != ma[WIDTH-1]);
    r.t = tacc + longint'(NG * PER);
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one request; the edge that samples it is taken as the accept edge.
  task automatic issue(input logic [WIDTH-1:0] ia, ib, input logic ic, is, input bit push);
    start = 1'b1; a = ia; b = ib; cin = ic; sub = is;
    @(posedge clk);
    if (push) sb.push_back(model(ia, ib, ic, is, longint'($time)));
    #1;
    start = 1'b0;
    a   = WIDTH'($urandom);
    b   = WIDTH'($urandom);
    cin = 1'b0;
    sub = 1'b0;
  endtask

  // Issue, then advance to the DONE cycle; optionally let it drop to IDLE.
  task automatic run_op(input logic [WIDTH-1:0] ia, ib, input logic ic, is, input bit chain);
    issue(ia, ib, ic, is, 1'b1);
    repeat (NG) @(posedge clk);
    #1;
    if (!chain) begin
      repeat (2) @(posedge clk);
      #1;
    end
  endtask

  // Monitor: pops the scoreboard on every done pulse and checks that the
  // result is held while idle.
  initial begin : monitor
    exp_t e, held;
    bit   have_res;
    have_res = 1'b0;
    held = '{s: '0, c: 1'b0, v: 1'b0, t: 0};
    forever begin
      @(negedge clk);
      if (rst) begin
        have_res = 1'b0;
      end else if (done) begin
        done_cnt++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done at %0t: s=%0h none expected", $time, s);
        end else begin
          e = sb.pop_front();
          chk("done_time", 64'(longint'($time) - PER/2), 64'(e.t));
          chk("sum",  64'(s),    64'(e.s));
          chk("cout", 64'(cout), 64'(e.c));
          chk("ovf",  64'(ovf),  64'(e.v));
          chk("busy_in_done", 64'(busy), 64'd0);
          held = e;
          have_res = 1'b1;
        end
      end else if (!busy && have_res) begin
        chk("hold_s",    64'(s),    64'(held.s));
        chk("hold_cout", 64'(cout), 64'(held.c));
        chk("hold_ovf",  64'(ovf),  64'(held.v));
      end
    end
  end

  initial begin : stim
    int d0;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s",    64'(s),    64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
    chk("rst_ovf",  64'(ovf),  64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    // Start held together with reset must be ignored.
    start = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_over_start_busy", 64'(busy), 64'd0);
    start = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Wrap, signed overflow, carry-in.
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    run_op(16'h1234, 16'h0000, 1'b1, 1'b0, 1'b0);

    // Start during RUN is ignored: exactly one done with 1+1.
    d0 = done_cnt;
    issue(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    start = 1'b1; a = 16'hAAAA; b = 16'h5555;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (NG + 6) @(posedge clk);
    #1;
    chk("run_start_one_done", 64'(done_cnt - d0), 64'd1);

    // Reset in the second RUN cycle aborts with no done.
    d0 = done_cnt;
    issue(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_s",    64'(s),    64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    for (int i = 0; i < 8; i++) begin
      chk("abort_no_done", 64'(done), 64'd0);
      @(posedge clk);
      #1;
    end
    chk("abort_done_cnt", 64'(done_cnt - d0), 64'd0);

    // Back-to-back: second start in the DONE cycle.
    issue(16'h0001, 16'h0002, 1'b0, 1'b0, 1'b1);
    repeat (NG - 1) @(posedge clk);
    #1;
    chk("b2b_last_run_busy", 64'(busy), 64'd1);
    @(posedge clk);
    #1;
    chk("b2b_done_cycle", 64'(done), 64'd1);
    issue(16'h0008, 16'h0008, 1'b0, 1'b0, 1'b1);
    chk("b2b_no_idle", 64'(busy), 64'd1);
    repeat (NG + 2) @(posedge clk);
    #1;

    if (SUB_ON) begin
      run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b0);
      run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0);
    end

    // Randomized operations, some chained in the DONE cycle.
    for (int n = 0; n < 60; n++) begin
      run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom),
             SUB_ON ? 1'($urandom) : 1'b0, (n != 59) && ($urandom_range(0, 1) == 1));
    end
    // Corner operands.
    run_op(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0);
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    run_op(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
